// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the EX stage; one quotient bit per clock.
// Returns {remainder, quotient} with sign correction for signed DIV.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        BUSY    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quot_next;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_op1_abs;
    logic [WIDTH-1:0] w_op2_abs;

    always_comb begin
        w_shift     = {r_rem, r_dividend[WIDTH-1]};
        w_diff      = w_shift - {1'b0, r_divisor};
        // Bit WIDTH of the difference is the borrow: set means restore
        w_qbit      = ~w_diff[WIDTH];
        w_rem_next  = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_quot_next = {r_quot[WIDTH-2:0], w_qbit};
        w_quot_fix  = r_neg_q ? -w_quot_next : w_quot_next;
        w_rem_fix   = r_neg_r ? -w_rem_next : w_rem_next;
        w_op1_abs   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        w_op2_abs   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            result_o   <= '0;
            ready_o    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            r_state <= DIVZERO;
                        end else begin
                            r_state    <= BUSY;
                            r_cnt      <= '0;
                            r_dividend <= w_op1_abs;
                            r_divisor  <= w_op2_abs;
                            r_rem      <= '0;
                            r_quot     <= '0;
                            r_neg_q    <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            r_neg_r    <= signed_div_i & opdata1_i[WIDTH-1];
                        end
                    end
                end
                DIVZERO: begin
                    if (annul_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_state  <= DONE;
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (annul_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_rem      <= w_rem_next;
                        r_quot     <= w_quot_next;
                        r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
                        r_cnt      <= r_cnt + CW'(1);
                        if (r_cnt == CW'(WIDTH - 1)) begin
                            r_state  <= DONE;
                            ready_o  <= 1'b1;
                            result_o <= {w_rem_fix, w_quot_fix};
                        end
                    end
                end
                DONE: begin
                    // Holding start high keeps the result; a new divide needs start seen low
                    if (!start_i || annul_i) begin
                        r_state  <= IDLE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero,
// annul, asynchronous reset and start-held-in-DONE behaviour.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_tests;
    int n_fail;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one division, scramble operands after capture, check latency/result/teardown
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk); #1;
        opdata1_i    = 32'hDEADBEEF;
        opdata2_i    = 32'h00000003;
        signed_div_i = ~sgn;
        n = 0;
        while (ready_o !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_res"}, result_o, exp);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_rdy_fall"}, 64'(ready_o), 64'd0);
        chk({tag, "_res_clr"}, result_o, 64'd0);
    endtask

    initial begin
        int  n;
        logic seen;
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #2;
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        run_div("divu_100_7",    1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 32);
        run_div("div_m7_2",      1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 32);
        run_div("div_7_m2",      1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 32);
        run_div("div_m100_m7",   1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 32);
        run_div("divu_m7_2",     1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 32);
        run_div("div_5_0",       1'b1, 32'd5,          32'd0,          64'h0,                 1);
        run_div("divu_max_1",    1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 32);
        run_div("div_min_m1",    1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 32);
        run_div("divu_3_10",     1'b0, 32'd3,          32'd10,         64'h00000003_00000000, 32);

        // Annul during the 10th BUSY cycle
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd10;
        start_i      = 1'b1;
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        annul_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("annul_no_ready", 64'(seen), 64'd0);
        run_div("divu_1000_10", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 32);

        // Start held high in DONE must hold the result, not restart
        signed_div_i = 1'b0;
        opdata1_i    = 32'd50;
        opdata2_i    = 32'd6;
        start_i      = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (ready_o !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        chk("hold_lat", 64'(n), 64'd32);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o !== 1'b1 || result_o !== 64'h00000002_00000008) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("hold_stable", 64'(seen), 64'd0);

        // Asynchronous reset while DONE with start still high
        #2 rst = 1'b0;
        #1;
        chk("rst_done_ready", 64'(ready_o), 64'd0);
        chk("rst_done_result", result_o, 64'd0);
        start_i = 1'b0;
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset mid-BUSY; no stale completion afterwards
        opdata1_i = 32'd12345;
        opdata2_i = 32'd17;
        start_i   = 1'b1;
        @(posedge clk); #1;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        chk("rst_busy_ready", 64'(ready_o), 64'd0);
        chk("rst_busy_result", result_o, 64'd0);
        start_i = 1'b0;
        #10 rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready_o !== 1'b0) seen = 1'b1;
        end
        chk("rst_busy_no_ready", 64'(seen), 64'd0);
        run_div("divu_after_rst", 1'b0, 32'd12345, 32'd17, 64'h00000003_000002D6, 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
